// File: rtl/led_framebuffer.sv
// Double-buffered LED pixel store: two read ports on the front bank, a CPU write port on the back bank.
// The optional back-buffer clear engine is compiled in with LED_FRAMEBUFFER_CLEAR_EN.
module led_framebuffer #(
    parameter int                     ADDR_WIDTH  = 11,
    parameter int                     PIXEL_WIDTH = 8,
    parameter logic [PIXEL_WIDTH-1:0] CLEAR_VALUE = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  pixelAddress0,
    output logic [PIXEL_WIDTH-1:0] pixel0,
    input  logic [ADDR_WIDTH-1:0]  pixelAddress1,
    output logic [PIXEL_WIDTH-1:0] pixel1,
    input  logic                   done,
    input  logic [ADDR_WIDTH:0]    wrAddr,
    input  logic [PIXEL_WIDTH-1:0] wrData,
    input  logic                   wrEn,
    output logic                   wrReady,
    input  logic                   swapReq,
    output logic                   swapPending,
    output logic                   swapAck,
    input  logic                   clearReq,
    output logic                   frontSel
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        PENDING
`ifdef LED_FRAMEBUFFER_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    state_t state_q, state_d;
    logic   front_q, front_d;
    logic   ack_q;
    logic   swap;

    logic [PIXEL_WIDTH-1:0] pix0_q, pix1_q;

    logic [PIXEL_WIDTH-1:0] a_top [DEPTH];
    logic [PIXEL_WIDTH-1:0] a_bot [DEPTH];
    logic [PIXEL_WIDTH-1:0] b_top [DEPTH];
    logic [PIXEL_WIDTH-1:0] b_bot [DEPTH];

    logic                   wr_top_en, wr_bot_en;
    logic [ADDR_WIDTH-1:0]  wr_addr_w;
    logic [PIXEL_WIDTH-1:0] wr_data_w;

`ifdef LED_FRAMEBUFFER_CLEAR_EN
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  latch_q, latch_d;
`else
    logic unused_clear;
    assign unused_clear = ^{clearReq, CLEAR_VALUE};
`endif

    always_comb begin
        state_d     = state_q;
        swap        = 1'b0;
        wrReady     = 1'b0;
        swapPending = 1'b0;
`ifdef LED_FRAMEBUFFER_CLEAR_EN
        cnt_d       = cnt_q;
        latch_d     = latch_q;
`endif
        case (state_q)
            IDLE: begin
                wrReady = 1'b1;
                if (swapReq) begin
                    if (done) swap = 1'b1;
                    else      state_d = PENDING;
                end
`ifdef LED_FRAMEBUFFER_CLEAR_EN
                else if (clearReq) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    latch_d = 1'b0;
                end
`endif
            end
            PENDING: begin
                swapPending = 1'b1;
                if (done) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef LED_FRAMEBUFFER_CLEAR_EN
            CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (swapReq) latch_d = 1'b1;
                // A swap requested during the clear is honoured on its final cycle.
                if (cnt_q == '1) begin
                    cnt_d   = '0;
                    latch_d = 1'b0;
                    state_d = IDLE;
                    if (latch_q || swapReq) begin
                        if (done) swap = 1'b1;
                        else      state_d = PENDING;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        front_d = front_q ^ swap;

        wr_top_en = 1'b0;
        wr_bot_en = 1'b0;
        wr_addr_w = wrAddr[ADDR_WIDTH-1:0];
        wr_data_w = wrData;
        if (wrReady && wrEn) begin
            wr_top_en = ~wrAddr[ADDR_WIDTH];
            wr_bot_en = wrAddr[ADDR_WIDTH];
        end
`ifdef LED_FRAMEBUFFER_CLEAR_EN
        if (state_q == CLEAR) begin
            wr_top_en = 1'b1;
            wr_bot_en = 1'b1;
            wr_addr_w = cnt_q;
            wr_data_w = CLEAR_VALUE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            front_q <= 1'b0;
            ack_q   <= 1'b0;
`ifdef LED_FRAMEBUFFER_CLEAR_EN
            cnt_q   <= '0;
            latch_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            ack_q   <= swap;
`ifdef LED_FRAMEBUFFER_CLEAR_EN
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
`endif
        end
    end

    // Back bank is the one not currently in front: bank A is written while B is displayed.
    always_ff @(posedge clk) begin
        if (wr_top_en &&  front_q) a_top[wr_addr_w] <= wr_data_w;
        if (wr_bot_en &&  front_q) a_bot[wr_addr_w] <= wr_data_w;
        if (wr_top_en && !front_q) b_top[wr_addr_w] <= wr_data_w;
        if (wr_bot_en && !front_q) b_bot[wr_addr_w] <= wr_data_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix0_q <= '0;
            pix1_q <= '0;
        end else begin
            pix0_q <= front_q ? b_top[pixelAddress0] : a_top[pixelAddress0];
            pix1_q <= front_q ? b_bot[pixelAddress1] : a_bot[pixelAddress1];
        end
    end

    assign pixel0   = pix0_q;
    assign pixel1   = pix1_q;
    assign swapAck  = ack_q;
    assign frontSel = front_q;

endmodule

// File: tb/tb_led_framebuffer.sv
// Bench for led_framebuffer: directed vector table, reset corner cases, randomized run against an array model.
// Clear-engine checks are compiled in with LED_FRAMEBUFFER_CLEAR_EN.
module tb_led_framebuffer;

    localparam int AW    = 11;
    localparam int PW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pixelAddress0, pixelAddress1;
    logic [PW-1:0] pixel0, pixel1;
    logic          done;
    logic [AW:0]   wrAddr;
    logic [PW-1:0] wrData;
    logic          wrEn, wrReady, swapReq, swapPending, swapAck, clearReq, frontSel;

    led_framebuffer #(
        .ADDR_WIDTH (AW),
        .PIXEL_WIDTH(PW),
        .CLEAR_VALUE(8'h11)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixelAddress0(pixelAddress0),
        .pixel0       (pixel0),
        .pixelAddress1(pixelAddress1),
        .pixel1       (pixel1),
        .done         (done),
        .wrAddr       (wrAddr),
        .wrData       (wrData),
        .wrEn         (wrEn),
        .wrReady      (wrReady),
        .swapReq      (swapReq),
        .swapPending  (swapPending),
        .swapAck      (swapAck),
        .clearReq     (clearReq),
        .frontSel     (frontSel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [AW:0] wa, input logic [PW-1:0] wd,
                         input logic sr, input logic dn, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1);
        wrEn          = we;
        wrAddr        = wa;
        wrData        = wd;
        swapReq       = sr;
        done          = dn;
        pixelAddress0 = a0;
        pixelAddress1 = a1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        clearReq = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
    endtask

    typedef struct {
        logic          we;
        logic [AW:0]   wa;
        logic [PW-1:0] wd;
        logic          sr;
        logic          dn;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        int            rep;
        logic          ready;
        logic          pend;
        logic          front;
        logic          ack;
        logic          chkpix;
        logic [PW-1:0] p0;
        logic [PW-1:0] p1;
    } vec_t;

    // Reference model: whole-frame arrays indexed [bank][half][addr]
    logic [PW-1:0] mem [2][2][DEPTH];
    logic          m_front;
    logic          m_pend;

    task automatic mstep(input logic we, input logic [AW:0] wa, input logic [PW-1:0] wd,
                         input logic sr, input logic dn, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic chkpix);
        logic [PW-1:0] e0, e1;
        logic          sw;
        drive(we, wa, wd, sr, dn, a0, a1);
        #1;
        chk("m_wrReady", 32'(wrReady), 32'(!m_pend));
        chk("m_swapPending", 32'(swapPending), 32'(m_pend));
        e0 = mem[m_front][0][a0];
        e1 = mem[m_front][1][a1];
        sw = dn && (m_pend || sr);
        if (we && !m_pend) mem[!m_front][wa[AW]][wa[AW-1:0]] = wd;
        if (sw) begin
            m_front = !m_front;
            m_pend  = 1'b0;
        end else if (sr) begin
            m_pend = 1'b1;
        end
        tick();
        chk("m_frontSel", 32'(frontSel), 32'(m_front));
        chk("m_swapAck", 32'(swapAck), 32'(sw));
        if (chkpix) begin
            chk("m_pixel0", 32'(pixel0), 32'(e0));
            chk("m_pixel1", 32'(pixel1), 32'(e1));
        end
    endtask

    vec_t tbl[$];

    initial begin
        int n;
        int unsigned ca[3];
        ca = '{0, 1023, 2047};

        tbl.push_back('{1'b1, 12'h005, 8'hA5, 1'b0, 1'b0, 11'd0, 11'd0,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 12'h805, 8'h3C, 1'b0, 1'b0, 11'd0, 11'd0,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 11'd0, 11'd0,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 11'd0, 11'd0, 99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 11'd0, 11'd0,  1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 11'd5, 11'd5,  1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C});
        tbl.push_back('{1'b1, 12'h005, 8'h5A, 1'b0, 1'b0, 11'd0, 11'd0,  1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 12'h805, 8'hC3, 1'b0, 1'b0, 11'd0, 11'd0,  1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 11'd0, 11'd0,  1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 12'h005, 8'hFF, 1'b0, 1'b0, 11'd0, 11'd0,  1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 11'd0, 11'd0,  1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 11'd5, 11'd5,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 8'hC3});
        tbl.push_back('{1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 11'd0, 11'd0,  1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 11'd5, 11'd5,  1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C});
        tbl.push_back('{1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 11'd0, 11'd0,  1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 11'd5, 11'd5,  1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C});

        rst = 1'b1;
        clearReq = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        chk("rst_frontSel", 32'(frontSel), 32'd0);
        chk("rst_swapAck", 32'(swapAck), 32'd0);
        chk("rst_swapPending", 32'(swapPending), 32'd0);
        chk("rst_wrReady", 32'(wrReady), 32'd1);
        chk("rst_pixel0", 32'(pixel0), 32'd0);
        chk("rst_pixel1", 32'(pixel1), 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].sr, tbl[i].dn, tbl[i].a0, tbl[i].a1);
                #1;
                chk($sformatf("v%0d_wrReady", i), 32'(wrReady), 32'(tbl[i].ready));
                chk($sformatf("v%0d_swapPending", i), 32'(swapPending), 32'(tbl[i].pend));
                tick();
                chk($sformatf("v%0d_frontSel", i), 32'(frontSel), 32'(tbl[i].front));
                chk($sformatf("v%0d_swapAck", i), 32'(swapAck), 32'(tbl[i].ack));
                if (tbl[i].chkpix) begin
                    chk($sformatf("v%0d_pixel0", i), 32'(pixel0), 32'(tbl[i].p0));
                    chk($sformatf("v%0d_pixel1", i), 32'(pixel1), 32'(tbl[i].p1));
                end
            end
        end

        // Reset while a swap is pending discards it; a later done must not swap.
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        chk("pend_before_rst", 32'(swapPending), 32'd1);
        do_reset();
        #1;
        chk("pend_rst_wrReady", 32'(wrReady), 32'd1);
        chk("pend_rst_swapPending", 32'(swapPending), 32'd0);
        chk("pend_rst_frontSel", 32'(frontSel), 32'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, '0, '0);
        tick();
        chk("pend_rst_done_frontSel", 32'(frontSel), 32'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        chk("pend_rst_swapAck", 32'(swapAck), 32'd0);

        // Randomized phase: fill both banks so every read has a known value.
        do_reset();
        m_front = 1'b0;
        m_pend  = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int h = 0; h < 2; h++)
                for (int a = 0; a < DEPTH; a++)
                    mstep(1'b1, {1'(h), AW'(a)}, PW'($urandom), 1'b0, 1'b0, '0, '0, 1'b0);
            mstep(1'b0, '0, '0, 1'b1, 1'b1, '0, '0, 1'b0);
        end
        for (int k = 0; k < 3000; k++) begin
            logic [AW-1:0] ra0, ra1;
            ra0 = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
            ra1 = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
            mstep(1'($urandom), {1'($urandom), AW'($urandom_range(0, 31))}, PW'($urandom),
                  ($urandom % 12 == 0), ($urandom % 8 == 0), ra0, ra1, 1'b1);
        end

`ifdef LED_FRAMEBUFFER_CLEAR_EN
        do_reset();
        clearReq = 1'b1;
        #1;
        chk("clr_req_wrReady", 32'(wrReady), 32'd1);
        tick();
        clearReq = 1'b0;
        n = 0;
        while (wrReady === 1'b0 && n < 4000) begin
            n++;
            tick();
        end
        chk("clr_busy_cycles", 32'(n), 32'd2048);
        drive(1'b0, '0, '0, 1'b1, 1'b1, '0, '0);
        tick();
        chk("clr_swap_frontSel", 32'(frontSel), 32'd1);
        foreach (ca[j]) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, AW'(ca[j]), AW'(ca[j]));
            tick();
            chk($sformatf("clr_pixel0_%0d", ca[j]), 32'(pixel0), 32'h11);
            chk($sformatf("clr_pixel1_%0d", ca[j]), 32'(pixel1), 32'h11);
        end

        // Reset mid-clear with a latched swap: back to IDLE, request dropped.
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        for (int c = 1; c < 500; c++) begin
            swapReq = (c == 100);
            tick();
        end
        swapReq = 1'b0;
        chk("clr_mid_wrReady", 32'(wrReady), 32'd0);
        do_reset();
        #1;
        chk("clr_rst_wrReady", 32'(wrReady), 32'd1);
        chk("clr_rst_frontSel", 32'(frontSel), 32'd0);
        for (int c = 0; c < 5; c++) begin
            done = (c == 0);
            tick();
            chk("clr_rst_swapAck", 32'(swapAck), 32'd0);
            chk("clr_rst_front_hold", 32'(frontSel), 32'd0);
        end
        done = 1'b0;
`else
        do_reset();
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("noclr_wrReady", 32'(wrReady), 32'd1);
            tick();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
